// File: rtl/imm_gen_pkg.sv
// Shared constants for the registered immediate generator: imm_src encodings
// and occupancy-state encodings of the two-entry output buffer.
package imm_gen_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for I/S/B/U/J (and Z when IMM_GEN_ZICSR_EN
// is defined); reserved or disabled encodings give imm=0 with illegal=1.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;
  logic        s;
  logic        unused_opcode;

  assign s             = instr[31];
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    imm32   = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: imm32 = {{20{s}}, instr[31:20]};
      IMM_S: imm32 = {{20{s}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
      IMM_Z: imm32 = {27'b0, instr[19:15]};
`endif
      default: illegal = 1'b1;
    endcase
  end

  // Every 32-bit result already carries its sign in bit 31 (zero for zimm).
  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshakes and a two-entry
// skid buffer (registered in_ready). Optional zimm support: IMM_GEN_ZICSR_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [XLEN-1:0]  new_imm;
  logic             new_ill;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_ill;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_ill;
  logic             push;
  logic             pop;
  logic             load_main_new;
  logic             load_main_skid;
  logic             load_skid;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (new_imm),
    .illegal (new_ill)
  );

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          next_state    = ST_ONE;
          load_main_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          load_main_new = 1'b1;
        end else if (push) begin
          next_state = ST_TWO;
          load_skid  = 1'b1;
        end else if (pop) begin
          next_state = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // The skid entry is always the younger one, so it refills main.
        if (pop) begin
          next_state     = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != ST_TWO);
    end
  end

  // NOTE: data registers are reset too, since the outputs must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_imm <= '0;
      main_tag <= '0;
      main_ill <= 1'b0;
      skid_imm <= '0;
      skid_tag <= '0;
      skid_ill <= 1'b0;
    end else begin
      if (load_main_new) begin
        main_imm <= new_imm;
        main_tag <= in_tag;
        main_ill <= new_ill;
      end else if (load_main_skid) begin
        main_imm <= skid_imm;
        main_tag <= skid_tag;
        main_ill <= skid_ill;
      end
      if (load_skid) begin
        skid_imm <= new_imm;
        skid_tag <= in_tag;
        skid_ill <= new_ill;
      end
    end
  end

  assign out_valid   = (state != ST_EMPTY);
  assign out_imm     = main_imm;
  assign out_tag     = main_tag;
  assign out_illegal = main_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: table-driven format vectors, a scoreboard
// queue for ordering, and hand-written backpressure/streaming/reset sequences.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_imm;

  logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_illegal;
  logic [31:0] v64_instr;
  logic [2:0]  v64_src;
  logic [4:0]  v64_out_tag;
  logic [63:0] v64_out_imm;

  exp_t sb[$];
  exp_t cur_exp;
  int   total = 0;
  int   passed = 0;
  int   out_count = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
    .instr(v64_instr), .imm_src(v64_src), .in_tag(5'd0),
    .out_valid(v64_out_valid), .out_ready(1'b1), .out_imm(v64_out_imm),
    .out_tag(v64_out_tag), .out_illegal(v64_out_illegal)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Handshakes complete on the next rising edge; inputs only change 1 time unit
  // after a rising edge, so the falling edge sees exactly what that edge will see.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", {59'd0, out_tag}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          check("sb_imm", {32'd0, out_imm}, {32'd0, e.imm});
          check("sb_tag", {59'd0, out_tag}, {59'd0, e.tag});
          check("sb_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
          out_count++;
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic drive(input vec_t v);
    instr    = v.instr;
    imm_src  = v.src;
    in_tag   = v.tag;
    cur_exp  = '{v.imm, v.tag, v.ill};
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge with in_valid still high.
  task automatic send(input vec_t v, output int waited);
    drive(v);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 64'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] s, input logic [4:0] t,
                              input logic [31:0] m, input logic l);
    vec_t v;
    v.instr = i; v.src = s; v.tag = t; v.imm = m; v.ill = l;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    int   w;
    int   sumw;
    int   c0;
    int   k;

    tbl[0] = mk(32'hFFF00093, IMM_I, 5'd1, 32'hFFFFFFFF, 1'b0);
    tbl[1] = mk(32'hFE112E23, IMM_S, 5'd2, 32'hFFFFFFFC, 1'b0);
    // instr[7]=1 here, so bit 11 of the B immediate is set.
    tbl[2] = mk(32'hFE000EE3, IMM_B, 5'd3, 32'hFFFFFFFC, 1'b0);
    tbl[3] = mk(32'h80000037, IMM_U, 5'd4, 32'h80000000, 1'b0);
    tbl[4] = mk(32'h800000EF, IMM_J, 5'd5, 32'hFFF00000, 1'b0);
    tbl[5] = mk(32'h7E000FE3, IMM_B, 5'd6, 32'h00000FFE, 1'b0);
    tbl[6] = mk(32'h7FFFF0EF, IMM_J, 5'd7, 32'h000FFFFE, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    tbl[7] = mk(32'h000F8073, IMM_Z, 5'd8, 32'h0000001F, 1'b0);
`else
    tbl[7] = mk(32'h000F8073, IMM_Z, 5'd8, 32'h00000000, 1'b1);
`endif
    tbl[8] = mk(32'hFFFFFFFF, 3'b111, 5'd9, 32'h00000000, 1'b1);
    tbl[9] = mk(32'hFFFFFFFF, 3'b110, 5'd10, 32'h00000000, 1'b1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; imm_src = '0; in_tag = '0; cur_exp = '{32'd0, 5'd0, 1'b0};
    v64_in_valid = 1'b0; v64_instr = '0; v64_src = '0;
    #12;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_imm", {32'd0, out_imm}, 64'd0);
    check("reset_out_tag", {59'd0, out_tag}, 64'd0);
    check("reset_out_illegal", {63'd0, out_illegal}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Format sweep: one entry at a time, visible one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i], w);
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_out_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    drain();

    // XLEN=64 instance.
    v64_instr = 32'h80000037; v64_src = IMM_U; v64_in_valid = 1'b1;
    @(posedge clk); #1; v64_in_valid = 1'b0;
    @(negedge clk);
    check("x64_u_valid", {63'd0, v64_out_valid}, 64'd1);
    check("x64_u_imm", v64_out_imm, 64'hFFFFFFFF80000000);
    @(posedge clk); #1;
    v64_instr = 32'h7FF00093; v64_src = IMM_I; v64_in_valid = 1'b1;
    @(posedge clk); #1; v64_in_valid = 1'b0;
    @(negedge clk);
    check("x64_i_imm", v64_out_imm, 64'h00000000000007FF);
    check("x64_i_illegal", {63'd0, v64_out_illegal}, 64'd0);
    @(posedge clk); #1;

    // Backpressure: two accepted, third waits until a pop frees a slot.
    out_ready = 1'b0;
    c0 = out_count;
    send(mk(32'h00100093, IMM_I, 5'h11, 32'h1, 1'b0), w);
    send(mk(32'h00200093, IMM_I, 5'h12, 32'h2, 1'b0), w);
    v = mk(32'hFFD00093, IMM_I, 5'h13, 32'hFFFFFFFD, 1'b0);
    drive(v);
    @(negedge clk);
    check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
    check("bp_out_tag_head", {59'd0, out_tag}, 64'h11);
    repeat (2) @(negedge clk);
    check("bp_in_ready_held", {63'd0, in_ready}, 64'd0);
    check("bp_out_tag_stable", {59'd0, out_tag}, 64'h11);
    check("bp_out_imm_stable", {32'd0, out_imm}, 64'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(v, w);
    check("bp_third_wait_cycles", w, 64'd1);
    in_valid = 1'b0;
    drain();
    check("bp_output_count", out_count - c0, 64'd3);

    // Streaming: one accept and one output per cycle.
    c0 = out_count;
    sumw = 0;
    for (int i = 0; i < 16; i++) begin
      k = i - 8;
      send(mk({k[11:0], 20'h00093}, IMM_I, 5'(i), k, 1'b0), w);
      sumw += w;
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    check("stream_in_ready_never_dropped", sumw, 64'd0);
    check("stream_output_count", out_count - c0, 64'd16);
    drain();

    // Async reset while full and stalled.
    out_ready = 1'b0;
    send(mk(32'h00100093, IMM_I, 5'h1A, 32'h1, 1'b0), w);
    send(mk(32'h00200093, IMM_I, 5'h1B, 32'h2, 1'b0), w);
    drive(mk(32'h00300093, IMM_I, 5'h1C, 32'h3, 1'b0));
    @(negedge clk);
    check("rst_pre_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_async_out_imm", {32'd0, out_imm}, 64'd0);
    check("rst_async_out_tag", {59'd0, out_tag}, 64'd0);
    sb.delete();
    drive(mk(32'h00400093, IMM_I, 5'h1D, 32'h4, 1'b0));
    @(posedge clk); @(posedge clk); #1;
    check("rst_held_out_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    c0 = out_count;
    send(mk(32'h00500093, IMM_I, 5'h1E, 32'h5, 1'b0), w);
    check("rst_first_accept_wait", w, 64'd0);
    in_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("rst_only_new_entry", out_count - c0, 64'd1);
    check("rst_final_empty", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
